ysyx_25050148_mem_arb: RTL and testbench
========================================

// Module: ysyx_25050148_mem_arb
// PURPOSE
//  Arbiter between the IFU instruction fetch and the LSU data access for one shared memory port.
//  Each requester uses a valid/ready request channel and gets a one-cycle response pulse.
//  The block has a single outstanding transaction and a round-robin grant.
//  A watchdog times out a lost response so the single-cycle CPU never hangs.
// PARAMETERS
//  ADDR_WIDTH  32  address width, all channels
//  DATA_WIDTH  32  data width; write mask is DATA_WIDTH/8 bits
//  TIMEOUT     16  max cycles in WAIT before a forced error response (>=2)
// PORTS
//  clk             in   1    clock; all state on posedge
//  rst             in   1    synchronous reset, active high
//  ifu_req_valid   in   1    IFU read request
//  ifu_req_ready   out  1    IFU request accepted this cycle
//  ifu_addr        in   AW   IFU fetch address
//  ifu_resp_valid  out  1    IFU response pulse
//  ifu_rdata       out  DW   IFU read data
//  lsu_req_valid   in   1    LSU request
//  lsu_req_ready   out  1    LSU request accepted this cycle
//  lsu_addr        in   AW   LSU address
//  lsu_wen         in   1    1 = write, 0 = read
//  lsu_wdata       in   DW   LSU write data
//  lsu_wmask       in   DW/8 LSU byte strobes
//  lsu_resp_valid  out  1    LSU response pulse (reads and writes)
//  lsu_rdata       out  DW   LSU read data
//  mem_req_valid   out  1    downstream request
//  mem_req_ready   in   1    downstream accepts request
//  mem_addr        out  AW   latched address
//  mem_wen         out  1    latched write enable (0 for IFU)
//  mem_wdata       out  DW   latched write data
//  mem_wmask       out  DW/8 latched strobes (0 for IFU)
//  mem_resp_valid  in   1    downstream response; never in the same cycle as mem_req_ready
//  mem_rdata       in   DW   downstream read data
//  err             out  1    sticky timeout flag
// BEHAVIOUR
//  Reset values: state=IDLE, last_grant=LSU, err=0, wdog=0, latched fields=0.
//  While rst=1, every valid and ready output is 0.
//  FSM states: IDLE, ISSUE, WAIT.
//  IDLE:
//   - Winner is the only valid requester; if both are valid, the one not equal to last_grant.
//   - Winner's req_ready=1 (combinational); loser's req_ready=0.
//   - On acceptance: latch addr, wen, wdata, wmask and owner; set last_grant=owner; go to ISSUE.
//   - mem_resp_valid is ignored.
//  ISSUE:
//   - mem_req_valid=1; mem_* are driven from the latched regs and stay stable until accepted.
//   - On mem_req_ready: go to WAIT and clear wdog.
//   - Both req_ready outputs are 0.
//  WAIT:
//   - wdog increments each cycle.
//   - On mem_resp_valid: owner's resp_valid=1 for exactly this cycle, owner's rdata=mem_rdata; go to IDLE.
//   - Else if wdog==TIMEOUT-1: owner's resp_valid=1, rdata=0, err<=1; go to IDLE.
//  Outputs:
//   - Non-owner resp_valid is always 0.
//   - rdata outputs are 0 whenever the matching resp_valid is 0.
//  Latency:
//   - Accept, then ISSUE for at least 1 cycle, then WAIT until the response.
//   - Minimum 3 cycles from acceptance to resp_valid with an immediate mem_req_ready and a 1-cycle memory.
//  A new request can be accepted in the cycle after resp_valid (IDLE).
//  The response is combinational from mem_resp_valid, so there is no extra response latency.
//  Reset mid-operation (ISSUE or WAIT):
//   - Drop the transaction; no resp_valid is issued.
//   - A late mem_resp_valid arriving in IDLE is ignored.
//  err clears only on rst. wdog saturates; it never wraps.
// TESTING
//  1. IFU read 0x80000000; mem_req_ready=1; response 1 cycle later with 0x00000413.
//     -> ifu_resp_valid pulses once with 0x00000413; lsu_resp_valid stays 0.
//  2. IFU and LSU both valid right after reset, then both valid again.
//     -> Grant order is IFU, LSU, IFU, LSU; loser's ready stays 0 while the other is served.
//  3. LSU write 0x80001000, wdata 0xdeadbeef, wmask 0xF; mem_req_ready low for 3 cycles.
//     -> mem_* fields stable and mem_wen=1 throughout; one lsu_resp_valid after the response.
//  4. TIMEOUT=16 and no mem_resp_valid.
//     -> After 16 WAIT cycles: owner resp_valid with rdata 0 and err=1.
//     -> A later stray mem_resp_valid produces no pulse; err stays 1.
//  5. rst asserted for 1 cycle while in WAIT; memory responds 2 cycles later.
//     -> No resp_valid, all ports idle; next IFU request completes normally.
//  6. IFU request held valid continuously with a 1-cycle memory.
//     -> One ifu_resp_valid every 4 cycles, addresses taken at each acceptance.

Source files
------------

// File: rtl/ysyx_25050148_mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU fetches and LSU accesses.
// One transaction in flight at a time; a watchdog forces an error response if memory goes silent.
module ysyx_25050148_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    err
);

  localparam int MW = DATA_WIDTH / 8;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  err_q, err_d;
  logic [WW-1:0]         wdog_q, wdog_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         wmask_q, wmask_d;

  logic grant_ifu, grant_lsu;
  logic in_idle, in_issue, in_wait;
  logic timeout_hit, resp_fire;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    in_idle   = (state_q == S_IDLE);
    in_issue  = (state_q == S_ISSUE);
    in_wait   = (state_q == S_WAIT);
    grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));
    grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));

    timeout_hit = (wdog_q == WDOG_LAST);
    resp_fire   = !rst && in_wait && (mem_resp_valid || timeout_hit);

    ifu_req_ready  = !rst && in_idle && grant_ifu;
    lsu_req_ready  = !rst && in_idle && grant_lsu;
    mem_req_valid  = !rst && in_issue;
    ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
    lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
    ifu_rdata      = (ifu_resp_valid && mem_resp_valid) ? mem_rdata : '0;
    lsu_rdata      = (lsu_resp_valid && mem_resp_valid) ? mem_rdata : '0;

    mem_addr  = addr_q;
    mem_wen   = wen_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
    err       = err_q;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;

    case (state_q)
      S_IDLE: begin
        if (grant_ifu) begin
          addr_d       = ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          state_d      = S_ISSUE;
        end else if (grant_lsu) begin
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          wdog_d  = '0;
        end
      end
      S_WAIT: begin
        // The counter saturates so it can never wrap back and miss the timeout.
        if (!timeout_hit) wdog_d = wdog_q + WW'(1);
        if (mem_resp_valid) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= OWN_LSU;
      owner_q      <= OWN_IFU;
      err_q        <= 1'b0;
      wdog_q       <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25050148_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter: grant order, stalls, timeout, reset and back-to-back fetches.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_ysyx_25050148_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastRespCyc = 0;
  int prevRespCyc = 0;

  ysyx_25050148_mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifuV, input logic [31:0] ifuA, input logic lsuV,
                               input logic [31:0] lsuA, input logic wen, input logic [31:0] wd,
                               input logic [3:0] wm);
    ifu_req_valid = ifuV;
    ifu_addr      = ifuA;
    lsu_req_valid = lsuV;
    lsu_addr      = lsuA;
    lsu_wen       = wen;
    lsu_wdata     = wd;
    lsu_wmask     = wm;
  endtask

  // Runs one transaction from the IDLE acceptance cycle through the response pulse.
  task automatic serve(input string tag, input bit lsuOwner, input int readyWait, input int respWait,
                       input logic [31:0] rd, input logic [31:0] expAddr, input logic expWen,
                       input logic [31:0] expWdata, input logic [3:0] expWmask, input bit dropValid);
    #1;
    checkOutput({tag, "_ifu_ready"}, ifu_req_ready, !lsuOwner);
    checkOutput({tag, "_lsu_ready"}, lsu_req_ready, lsuOwner);
    checkOutput({tag, "_idle_memvalid"}, mem_req_valid, 1'b0);
    tick();
    if (dropValid) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
    end
    if (!lsuOwner) ifu_addr = ifu_addr + 32'd4;
    for (int i = 0; i <= readyWait; i++) begin
      mem_req_ready = (i == readyWait);
      #1;
      checkOutput({tag, "_memvalid"}, mem_req_valid, 1'b1);
      checkOutput({tag, "_addr"}, mem_addr, expAddr);
      checkOutput({tag, "_wen"}, mem_wen, expWen);
      checkOutput({tag, "_wdata"}, mem_wdata, expWdata);
      checkOutput({tag, "_wmask"}, mem_wmask, expWmask);
      checkOutput({tag, "_issue_readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < respWait; i++) begin
      #1;
      checkOutput({tag, "_wait_resp"}, {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    #1;
    checkOutput({tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, lsuOwner ? 2'b01 : 2'b10);
    checkOutput({tag, "_rdata"}, lsuOwner ? lsu_rdata : ifu_rdata, rd);
    checkOutput({tag, "_other_rdata"}, lsuOwner ? ifu_rdata : lsu_rdata, 32'h0);
    prevRespCyc = lastRespCyc;
    lastRespCyc = cyc;
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h8000_1000, 1'b0, 32'h0, 4'h0);
    tick();
    tick();
    #1;
    checkOutput("rst_readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
    checkOutput("rst_memvalid", mem_req_valid, 1'b0);

    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    tick();
    #1;
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_fields", {mem_addr, mem_wen, mem_wmask}, 37'h0);
    checkOutput("reset_wdata", mem_wdata, 32'h0);
    checkOutput("reset_outputs", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 5'b0);
    tick();

    // Both requesters valid right after reset: IFU wins first because last grant resets to LSU.
    applyStimulus(1'b1, 32'h8000_0100, 1'b1, 32'h8000_2000, 1'b0, 32'h1111_1111, 4'hF);
    serve("rr1_ifu", 1'b0, 0, 1, 32'hA000_0001, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 1'b0);
    serve("rr2_lsu", 1'b1, 0, 1, 32'hA000_0002, 32'h8000_2000, 1'b0, 32'h1111_1111, 4'hF, 1'b0);
    serve("rr3_ifu", 1'b0, 0, 1, 32'hA000_0003, 32'h8000_0104, 1'b0, 32'h0, 4'h0, 1'b0);
    serve("rr4_lsu", 1'b1, 0, 1, 32'hA000_0004, 32'h8000_2000, 1'b0, 32'h1111_1111, 4'hF, 1'b1);

    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    serve("ifu_read", 1'b0, 0, 1, 32'h0000_0413, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1);

    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    serve("lsu_write", 1'b1, 3, 1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);

    // Memory never answers: the 16th WAIT cycle must produce the forced response.
    applyStimulus(1'b1, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    checkOutput("to_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checkOutput("to_memvalid", mem_req_valid, 1'b1);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      checkOutput("to_wait_quiet", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      tick();
    end
    #1;
    checkOutput("to_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b10);
    checkOutput("to_rdata", ifu_rdata, 32'h0);
    checkOutput("to_err_before", err, 1'b0);
    tick();
    #1;
    checkOutput("to_err_set", err, 1'b1);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_1234;
    #1;
    checkOutput("stray_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    checkOutput("stray_rdata", ifu_rdata, 32'h0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    #1;
    checkOutput("err_sticky", err, 1'b1);
    checkOutput("after_to_idle", mem_req_valid, 1'b0);
    tick();

    // Reset pulse in WAIT, then the memory answers late into IDLE.
    applyStimulus(1'b1, 32'h8000_0300, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    checkOutput("rw_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    checkOutput("rw_in_rst", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 5'b0);
    tick();
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
    checkOutput("rw_err_clr", err, 1'b0);
    checkOutput("rw_addr_clr", mem_addr, 32'h0);
    checkOutput("rw_idle", mem_req_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h00AB_CDEF;
    #1;
    checkOutput("rw_late_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    checkOutput("rw_late_rdata", ifu_rdata, 32'h0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    applyStimulus(1'b1, 32'h8000_0400, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    serve("rw_next", 1'b0, 0, 1, 32'h0000_0013, 32'h8000_0400, 1'b0, 32'h0, 4'h0, 1'b1);

    // IFU held valid; the fetch address advances during each ISSUE.
    applyStimulus(1'b1, 32'h8000_0500, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    serve("bb1", 1'b0, 0, 1, 32'hB000_0001, 32'h8000_0500, 1'b0, 32'h0, 4'h0, 1'b0);
    serve("bb2", 1'b0, 0, 1, 32'hB000_0002, 32'h8000_0504, 1'b0, 32'h0, 4'h0, 1'b0);
    checkOutput("bb_period2", 64'(lastRespCyc - prevRespCyc), 64'd4);
    serve("bb3", 1'b0, 0, 1, 32'hB000_0003, 32'h8000_0508, 1'b0, 32'h0, 4'h0, 1'b1);
    checkOutput("bb_period3", 64'(lastRespCyc - prevRespCyc), 64'd4);
    #1;
    checkOutput("final_idle", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 3'b000);
    checkOutput("final_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
